b16_dbg_host: RTL and testbench
===============================

Name: b16_dbg_host

Overview:
Host-side initiator for the b16 CPU debug register port. It receives command bytes from a byte-stream link (UART or JTAG shim) and drives the CPU's run, dr, dw, daddr and din signals. It captures dout, and returns response bytes on the same link. It also holds the breakpoint register, compares it against CPU fetch addresses, and halts the core on a match.

Parameters:
l, 16, data/register width (fixed 16; protocol is two bytes per word)
RUN_RST, 1, value of run after reset (1 = core free-running)
BP_RST, 16'hFFFF, reset value of breakpoint register
ACK, 8'h06, acknowledge byte
NAK, 8'h15, reject byte

Ports:
clk  in  1  system clock, same as CPU
reset  in  1  asynchronous, active-low
rx_data  in  8  command/argument byte from host link
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid & rx_ready at posedge
tx_data  out  8  response byte
tx_valid  out  1  response byte valid, held until accepted
tx_ready  in  1  link accepts tx_data at posedge when tx_valid & tx_ready
run  out  1  CPU run enable
dr  out  1  debug read strobe
dw  out  1  debug write strobe
daddr  out  3  debug register select (0=N pop, 1=R pop, 2=bp, 3=status, 4=P, 5=T, 6=R, 7=I)
din  out  16  debug write data
dout  in  16  debug read data (combinational from CPU while !run & dr)
cpu_addr  in  16  CPU bus address
cpu_rd  in  1  CPU read strobe
bp  out  16  breakpoint register, also routed to CPU bp input

Behaviour:
- Clock and reset: reset is asynchronous, active-low; clock is clk. On reset: state=IDLE, run=RUN_RST, bp=BP_RST, dr=dw=0, daddr=0, din=0, tx_valid=0, tx_data=0, bp_hit=0. rx_ready=1 because the state is IDLE.
- Command byte fields: [7:5]=op, [2:0]=a; [4:3] ignored.
- op 000 READ a: if run=1, send NAK. Else EXEC asserts dr=1, daddr=a for exactly one cycle, and dout is latched at that edge. Then send dout[15:8], then dout[7:0].
- op 001 WRITE a: takes two argument bytes, hi then lo. If run=1, send NAK after the arguments are consumed. Else EXEC asserts dw=1, daddr=a, din={hi,lo} for one cycle, then sends ACK.
- op 010 HALT: run<=0, send ACK.
- op 011 GO: bp_hit<=0, run<=1, send ACK.
- op 100 STEP: requires run=0, else NAK. Sets bp_hit<=0 and asserts run for exactly one clock, then run<=0. Sends ACK.
- op 101 SETBP: takes two argument bytes; bp<={hi,lo}; sends ACK. bp is legal while running.
- op 110 STATUS: sends one byte {run, bp_hit, 6'b0}.
- op 111: sends NAK.
- State machine:
  - IDLE: accept byte. Go to ARG_HI for 001/101, otherwise EXEC.
  - ARG_HI: accept byte, go to ARG_LO.
  - ARG_LO: accept byte, go to EXEC.
  - EXEC: one cycle, go to TX1.
  - TX1: hold until handshake, then go to TX2 (READ) or IDLE.
  - TX2: hold until handshake, then go to IDLE.
- rx_ready=1 only in IDLE/ARG_HI/ARG_LO. tx_valid=1 only in TX1/TX2. tx_data is stable while tx_valid=1 and not accepted.
- dr/dw are registered outputs, high only during the EXEC cycle, never both at once, never while run=1.
- Breakpoint: if run=1 and cpu_rd=1 and cpu_addr==bp at a posedge, then run<=0 and bp_hit<=1 at that edge.
  - Breakpoint beats a same-cycle STEP deassert (same result).
  - Breakpoint beats GO: if GO's EXEC and a match coincide, run ends 0 and bp_hit=1.
  - The match is ignored while run=0.
- HALT in EXEC with a simultaneous bp match: run=0 and bp_hit=1.
- READ of a=0 or a=1 pops the CPU stack. The bridge issues exactly one dr pulse per command; no retries.
- A mid-byte link stall has no timeout; the FSM waits indefinitely in ARG/TX states.
- Reset asserted mid-command aborts it: state=IDLE, no strobes, pending tx dropped.

Test Plan:
- Reset: after reset release -> run=1, bp=16'hFFFF, rx_ready=1, tx_valid=0, dr=dw=0.
- HALT (8'h40) -> ACK 8'h06, run=0. Then READ P (8'h04) with dout=16'h3FFE -> dr high one cycle with daddr=4; tx bytes 8'h3F then 8'hFE.
- WRITE T: 8'h25, 8'h12, 8'h34 while halted -> one-cycle dw, daddr=5, din=16'h1234, then ACK. The same sequence while running -> NAK 8'h15, no dw.
- SETBP 8'hA0, 8'h01, 8'h00, then GO 8'h60. Drive cpu_rd=1 with cpu_addr=16'h0100 -> run=0 the same edge. STATUS 8'hC0 -> 8'hC0?? no: expected byte 8'h40 (run=0, bp_hit=1).
- STEP 8'h80 while halted -> run high exactly one clock, ACK. STEP while running -> NAK with run unchanged. Opcode 8'hE0 -> NAK.
- Backpressure and reset: hold tx_ready=0 for 10 cycles during a READ -> tx_data stable, no extra dr. Assert reset during ARG_LO -> IDLE, no dw.

Source files
------------

// File: rtl/b16_dbg_host.sv
// b16 debug host: turns link command bytes into debug port strobes for the CPU,
// sends back response bytes, and holds the breakpoint register and its compare.
module b16_dbg_host #(
  parameter int          l       = 16,
  parameter logic        RUN_RST = 1'b1,
  parameter logic [15:0] BP_RST  = 16'hFFFF,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         run,
  output logic         dr,
  output logic         dw,
  output logic [2:0]   daddr,
  output logic [l-1:0] din,
  input  logic [l-1:0] dout,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_rd,
  output logic [l-1:0] bp
);

  typedef enum logic [2:0] {IDLE, ARG_HI, ARG_LO, EXEC, TX1, TX2} state_t;

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_HALT  = 3'b010;
  localparam logic [2:0] OP_GO    = 3'b011;
  localparam logic [2:0] OP_STEP  = 3'b100;
  localparam logic [2:0] OP_SETBP = 3'b101;
  localparam logic [2:0] OP_STAT  = 3'b110;

  state_t     state;
  logic [2:0] op, a;
  logic [7:0] hi, lo;     // argument bytes; lo also holds dout[7:0] for the second READ byte
  logic       ok;         // core was halted when the command committed to EXEC
  logic       two;        // response has a second byte
  logic       step_pend;  // drop run on the cycle after a STEP
  logic       bp_hit;

  // bits [4:3] of the command byte carry no meaning
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^rx_data[4:3];

  assign rx_ready = (state == IDLE) || (state == ARG_HI) || (state == ARG_LO);

  // command FSM, debug strobes, run/breakpoint control; breakpoint assignment last so it wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      run       <= RUN_RST;
      bp        <= BP_RST;
      bp_hit    <= 1'b0;
      dr        <= 1'b0;
      dw        <= 1'b0;
      daddr     <= 3'd0;
      din       <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      op        <= 3'd0;
      a         <= 3'd0;
      hi        <= 8'h00;
      lo        <= 8'h00;
      ok        <= 1'b0;
      two       <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      dr <= 1'b0;
      dw <= 1'b0;
      if (step_pend) begin
        run       <= 1'b0;
        step_pend <= 1'b0;
      end
      case (state)
        IDLE: if (rx_valid) begin
          op <= rx_data[7:5];
          a  <= rx_data[2:0];
          ok <= !run;
          if (rx_data[7:5] == OP_WRITE || rx_data[7:5] == OP_SETBP) begin
            state <= ARG_HI;
          end else begin
            state <= EXEC;
            daddr <= rx_data[2:0];
            dr    <= (rx_data[7:5] == OP_READ) && !run;
          end
        end
        ARG_HI: if (rx_valid) begin
          hi    <= rx_data;
          state <= ARG_LO;
        end
        ARG_LO: if (rx_valid) begin
          lo    <= rx_data;
          ok    <= !run;
          state <= EXEC;
          if (op == OP_WRITE) begin
            daddr <= a;
            din   <= {hi, rx_data};
            dw    <= !run;
          end
        end
        EXEC: begin
          state    <= TX1;
          tx_valid <= 1'b1;
          two      <= 1'b0;
          tx_data  <= ACK;
          case (op)
            OP_READ: if (ok) begin
              tx_data <= dout[15:8];
              lo      <= dout[7:0];
              two     <= 1'b1;
            end else begin
              tx_data <= NAK;
            end
            OP_WRITE: tx_data <= ok ? ACK : NAK;
            OP_HALT:  run <= 1'b0;
            OP_GO: begin
              run    <= 1'b1;
              bp_hit <= 1'b0;
            end
            OP_STEP: if (ok) begin
              run       <= 1'b1;
              bp_hit    <= 1'b0;
              step_pend <= 1'b1;
            end else begin
              tx_data <= NAK;
            end
            OP_SETBP: bp <= {hi, lo};
            OP_STAT:  tx_data <= {run, bp_hit, 6'b0};
            default:  tx_data <= NAK;
          endcase
        end
        TX1: if (tx_ready) begin
          if (two) begin
            tx_data <= lo;
            state   <= TX2;
          end else begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        TX2: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (run && cpu_rd && cpu_addr == bp) begin
        run    <= 1'b0;
        bp_hit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_b16_dbg_host.sv
// Bench for b16_dbg_host: directed protocol cases plus random command stream
// against a transaction-level model of run/bp/bp_hit and response bytes.
module tb_b16_dbg_host;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        run, dr, dw;
  logic [2:0]  daddr;
  logic [15:0] din, dout, bp;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rd = 1'b0;
  logic [15:0] dval = 16'h0000;

  int checks = 0;
  int failures = 0;

  // model state
  logic        m_run = 1'b1;
  logic        m_hit = 1'b0;
  logic [15:0] m_bp  = 16'hFFFF;

  // strobe monitors
  int          dr_cnt = 0, dw_cnt = 0, run_cyc = 0, bad = 0;
  logic [2:0]  dr_addr = 3'd0, dw_addr = 3'd0;
  logic [15:0] dw_din = 16'h0000;

  b16_dbg_host dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .run(run), .dr(dr), .dw(dw),
    .daddr(daddr), .din(din), .dout(dout), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .bp(bp)
  );

  // CPU side: read data only meaningful while halted and strobed
  assign dout = (!run && dr) ? dval : 16'hDEAD;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dr) begin dr_cnt <= dr_cnt + 1; dr_addr <= daddr; end
    if (dw) begin dw_cnt <= dw_cnt + 1; dw_addr <= daddr; dw_din <= din; end
    if ((dr && dw) || ((dr || dw) && run)) bad <= bad + 1;
    if (run) run_cyc <= run_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at a negedge after the byte was taken
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (!rx_ready) chk("rx_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv(output logic [7:0] b);
    int n = 0;
    logic got = 1'b0;
    b = 8'h00;
    while (!got && n < 300) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin b = tx_data; got = 1'b1; end
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    if (!got) chk("tx_timeout", 0, 1);
  endtask

  // one full command: model prediction, bytes out, responses in, side effects
  task automatic do_cmd(input string tag, input logic [7:0] c, input logic [15:0] arg,
                        input logic [15:0] dv);
    logic [2:0] op = c[7:5];
    logic [7:0] exp[$];
    logic [7:0] r;
    int d0 = dr_cnt, w0 = dw_cnt, rc0 = run_cyc;
    int e_dr = 0, e_dw = 0;
    logic e_step = 1'b0;
    dval = dv;
    case (op)
      3'd0: if (m_run) exp.push_back(NAK);
            else begin exp.push_back(dv[15:8]); exp.push_back(dv[7:0]); e_dr = 1; end
      3'd1: if (m_run) exp.push_back(NAK); else begin exp.push_back(ACK); e_dw = 1; end
      3'd2: begin m_run = 1'b0; exp.push_back(ACK); end
      3'd3: begin m_run = 1'b1; m_hit = 1'b0; exp.push_back(ACK); end
      3'd4: if (m_run) exp.push_back(NAK);
            else begin m_hit = 1'b0; e_step = 1'b1; exp.push_back(ACK); end
      3'd5: begin m_bp = arg; exp.push_back(ACK); end
      3'd6: exp.push_back({m_run, m_hit, 6'b0});
      default: exp.push_back(NAK);
    endcase
    send(c);
    if (op == 3'd1 || op == 3'd5) begin send(arg[15:8]); send(arg[7:0]); end
    foreach (exp[i]) begin recv(r); chk({tag, "_byte"}, r, exp[i]); end
    @(negedge clk);
    chk({tag, "_txidle"}, tx_valid, 0);
    chk({tag, "_drcnt"}, dr_cnt - d0, e_dr);
    chk({tag, "_dwcnt"}, dw_cnt - w0, e_dw);
    if (e_dr != 0) chk({tag, "_draddr"}, dr_addr, c[2:0]);
    if (e_dw != 0) begin chk({tag, "_dwaddr"}, dw_addr, c[2:0]); chk({tag, "_din"}, dw_din, arg); end
    if (e_step) chk({tag, "_steppulse"}, run_cyc - rc0, 1);
    chk({tag, "_run"}, run, m_run);
    chk({tag, "_bp"}, bp, m_bp);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] c;
    int d0, n;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_run", run, 1);
    chk("rst_bp", bp, 16'hFFFF);
    chk("rst_rxready", rx_ready, 1);
    chk("rst_txvalid", tx_valid, 0);
    chk("rst_dr", dr, 0);
    chk("rst_dw", dw, 0);

    do_cmd("halt", 8'h40, 16'h0, 16'h0);
    do_cmd("read_p", 8'h04, 16'h0, 16'h3FFE);
    do_cmd("write_t", 8'h25, 16'h1234, 16'h0);
    do_cmd("go", 8'h60, 16'h0, 16'h0);
    do_cmd("write_run", 8'h25, 16'h1234, 16'h0);
    do_cmd("read_run", 8'h04, 16'h0, 16'h0);

    // breakpoint hit while running
    do_cmd("setbp", 8'hA0, 16'h0100, 16'h0);
    cpu_addr = 16'h0104; cpu_rd = 1'b1;
    @(negedge clk);
    chk("bp_miss_run", run, 1);
    cpu_addr = 16'h0100;
    @(negedge clk);
    cpu_rd = 1'b0;
    m_run = 1'b0; m_hit = 1'b1;
    chk("bp_hit_run", run, 0);
    do_cmd("status_hit", 8'hC0, 16'h0, 16'h0);
    // match ignored while halted
    cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    chk("bp_halted_run", run, 0);

    do_cmd("step", 8'h80, 16'h0, 16'h0);
    do_cmd("status_step", 8'hC0, 16'h0, 16'h0);
    do_cmd("go2", 8'h60, 16'h0, 16'h0);
    do_cmd("step_run", 8'h80, 16'h0, 16'h0);
    do_cmd("bad_op", 8'hE0, 16'h0, 16'h0);
    do_cmd("halt2", 8'h40, 16'h0, 16'h0);

    // backpressure on a READ: first byte must hold, single dr
    d0 = dr_cnt;
    dval = 16'hA55A;
    send(8'h07);
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    chk("bpress_valid", tx_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bpress_hold", {tx_valid, tx_data}, {1'b1, 8'hA5});
      @(negedge clk);
    end
    recv(r); chk("bpress_b0", r, 8'hA5);
    recv(r); chk("bpress_b1", r, 8'h5A);
    chk("bpress_drcnt", dr_cnt - d0, 1);

    // random command stream
    for (int i = 0; i < 80; i++) begin
      c = {3'($urandom_range(0, 7)), 5'($urandom)};
      do_cmd("rand", c, 16'($urandom), 16'($urandom));
    end

    // reset in the middle of a WRITE argument phase
    do_cmd("halt3", 8'h40, 16'h0, 16'h0);
    d0 = dw_cnt;
    send(8'h25);
    send(8'h12);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rxready", rx_ready, 1);
    chk("midrst_txvalid", tx_valid, 0);
    chk("midrst_dw", dw, 0);
    reset = 1'b1;
    m_run = 1'b1; m_hit = 1'b0; m_bp = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("midrst_dwcnt", dw_cnt - d0, 0);
    do_cmd("status_rst", 8'hC0, 16'h0, 16'h0);

    chk("strobe_rules", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
